// File: rtl/turn_sequencer.sv
// -----------------------------------------------------------------------------
// turn_sequencer
//
// Game-flow controller for a BOARD_N x BOARD_N gobang board. It owns both
// stone bitmaps. It grants the move slot alternately to the AI (black, moves
// first) and to the keyboard player (white). Each proposal is validated and
// committed. After the commit, the mover's external win checker is sampled.
//
// Optional feature (compile-time macro TURN_TIMEOUT_EN):
//   When defined, the human turn is limited to TIMEOUT_CYCLES clk cycles.
//   If the time runs out, white forfeits and black wins.
//   When undefined, the human turn waits indefinitely.
//
// Ports:
//   clk                 system clock, all state changes on posedge
//   rst                 synchronous reset, active-low
//   ai_done             1-cycle pulse, AI proposes ai_row/ai_col
//   ai_row, ai_col      AI proposed square
//   hum_ok              1-cycle pulse, player confirms hum_row/hum_col
//   hum_row, hum_col    player cursor square
//   win_black           win flag for board_black around last_row/last_col
//   win_white           win flag for board_white around last_row/last_col
//   ai_enable           high while waiting for the AI move
//   hum_enable          high while waiting for the player move
//   board_black         black stones, bit index = row*BOARD_N+col
//   board_white         white stones, same indexing
//   last_row, last_col  most recently committed square
//   cur_row, cur_col    display cursor: ai_* in the AI turn, hum_* otherwise
//   who_win             0 playing, 1 black, 2 white, 3 draw
//   move_count          committed stones
//   illegal             1-cycle pulse, proposal rejected
// -----------------------------------------------------------------------------
module turn_sequencer #(
  parameter int          BOARD_N        = 15,
  parameter logic [31:0] TIMEOUT_CYCLES = 32'd1000000
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       ai_done,
  input  logic [3:0]                 ai_row,
  input  logic [3:0]                 ai_col,
  input  logic                       hum_ok,
  input  logic [3:0]                 hum_row,
  input  logic [3:0]                 hum_col,
  input  logic                       win_black,
  input  logic                       win_white,
  output logic                       ai_enable,
  output logic                       hum_enable,
  output logic [BOARD_N*BOARD_N-1:0] board_black,
  output logic [BOARD_N*BOARD_N-1:0] board_white,
  output logic [3:0]                 last_row,
  output logic [3:0]                 last_col,
  output logic [3:0]                 cur_row,
  output logic [3:0]                 cur_col,
  output logic [1:0]                 who_win,
  output logic [7:0]                 move_count,
  output logic                       illegal
);

  localparam int CELLS  = BOARD_N * BOARD_N;
  localparam int CELL_W = $clog2(CELLS);

  typedef enum logic [2:0] {
    AI_TURN,
    HUM_TURN,
    WRITE,
    CHECK,
    OVER
  } state_t;

  state_t           state_reg, state_next;
  logic [CELLS-1:0] board_black_reg, board_black_next;
  logic [CELLS-1:0] board_white_reg, board_white_next;
  logic [3:0]       last_row_reg, last_row_next;
  logic [3:0]       last_col_reg, last_col_next;
  logic [1:0]       who_win_reg, who_win_next;
  logic [7:0]       move_count_reg, move_count_next;
  logic             illegal_reg, illegal_next;
  logic [3:0]       pend_row_reg, pend_row_next;
  logic [3:0]       pend_col_reg, pend_col_next;
  logic             pend_white_reg, pend_white_next;

  // Proposal from whichever side currently holds the turn. The other side's
  // pulse never reaches the legality logic, so it can never raise illegal.
  logic              prop_valid;
  logic [3:0]        prop_row, prop_col;
  logic              prop_in_range, prop_free, prop_legal;
  logic [CELL_W-1:0] prop_cell, pend_cell;
  logic [CELLS-1:0]  pend_onehot;
  logic              mover_win;
  logic              timed_out;

  always_comb begin
    prop_valid = 1'b0;
    prop_row   = hum_row;
    prop_col   = hum_col;
    if (state_reg == AI_TURN) begin
      prop_valid = ai_done;
      prop_row   = ai_row;
      prop_col   = ai_col;
    end else if (state_reg == HUM_TURN) begin
      prop_valid = hum_ok;
    end
  end

  // The cell index wraps for off-board squares. It is only trusted when
  // prop_in_range is true.
  assign prop_in_range = (int'(prop_row) < BOARD_N) && (int'(prop_col) < BOARD_N);
  assign prop_cell     = CELL_W'(int'(prop_row) * BOARD_N + int'(prop_col));
  assign prop_free     = prop_in_range &&
                         !(board_black_reg[prop_cell] || board_white_reg[prop_cell]);
  assign prop_legal    = prop_valid && prop_free;

  // One-hot decode of the latched square. WRITE ORs this into the mover's
  // bitmap.
  assign pend_cell = CELL_W'(int'(pend_row_reg) * BOARD_N + int'(pend_col_reg));

  genvar gi;
  generate
    for (gi = 0; gi < CELLS; gi++) begin : g_decode
      assign pend_onehot[gi] = (pend_cell == CELL_W'(gi));
    end
  endgenerate

  // Only the mover's checker is consulted. The opponent's flag is ignored.
  assign mover_win = pend_white_reg ? win_white : win_black;

`ifdef TURN_TIMEOUT_EN
  logic [31:0] timer_reg, timer_next;
  assign timed_out = (state_reg == HUM_TURN) && (timer_reg == TIMEOUT_CYCLES - 32'd1);
`else
  logic unused_timeout;
  assign timed_out      = 1'b0;
  assign unused_timeout = ^TIMEOUT_CYCLES;
`endif

  always_comb begin
    state_next       = state_reg;
    board_black_next = board_black_reg;
    board_white_next = board_white_reg;
    last_row_next    = last_row_reg;
    last_col_next    = last_col_reg;
    who_win_next     = who_win_reg;
    move_count_next  = move_count_reg;
    illegal_next     = 1'b0;
    pend_row_next    = pend_row_reg;
    pend_col_next    = pend_col_reg;
    pend_white_next  = pend_white_reg;
`ifdef TURN_TIMEOUT_EN
    timer_next       = timer_reg;
`endif
    case (state_reg)
      AI_TURN, HUM_TURN: begin
        if (prop_legal) begin
          pend_row_next   = prop_row;
          pend_col_next   = prop_col;
          pend_white_next = (state_reg == HUM_TURN);
          state_next      = WRITE;
        end else begin
          illegal_next = prop_valid;
          // A legal move in the last cycle takes priority over the forfeit.
          if (timed_out) begin
            who_win_next = 2'd1;
            state_next   = OVER;
          end
        end
`ifdef TURN_TIMEOUT_EN
        if (state_reg == HUM_TURN) begin
          timer_next = timer_reg + 32'd1;
        end
`endif
      end
      WRITE: begin
        if (pend_white_reg) begin
          board_white_next = board_white_reg | pend_onehot;
        end else begin
          board_black_next = board_black_reg | pend_onehot;
        end
        last_row_next   = pend_row_reg;
        last_col_next   = pend_col_reg;
        move_count_next = move_count_reg + 8'd1;
        state_next      = CHECK;
      end
      CHECK: begin
`ifdef TURN_TIMEOUT_EN
        timer_next = 32'd0;
`endif
        if (mover_win) begin
          who_win_next = pend_white_reg ? 2'd2 : 2'd1;
          state_next   = OVER;
        end else if (move_count_reg == 8'(CELLS)) begin
          who_win_next = 2'd3;
          state_next   = OVER;
        end else begin
          state_next = pend_white_reg ? AI_TURN : HUM_TURN;
        end
      end
      OVER: begin
        state_next = OVER;
      end
      default: begin
        state_next = AI_TURN;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg       <= AI_TURN;
      board_black_reg <= '0;
      board_white_reg <= '0;
      last_row_reg    <= 4'd0;
      last_col_reg    <= 4'd0;
      who_win_reg     <= 2'd0;
      move_count_reg  <= 8'd0;
      illegal_reg     <= 1'b0;
      pend_row_reg    <= 4'd0;
      pend_col_reg    <= 4'd0;
      pend_white_reg  <= 1'b0;
`ifdef TURN_TIMEOUT_EN
      timer_reg       <= 32'd0;
`endif
    end else begin
      state_reg       <= state_next;
      board_black_reg <= board_black_next;
      board_white_reg <= board_white_next;
      last_row_reg    <= last_row_next;
      last_col_reg    <= last_col_next;
      who_win_reg     <= who_win_next;
      move_count_reg  <= move_count_next;
      illegal_reg     <= illegal_next;
      pend_row_reg    <= pend_row_next;
      pend_col_reg    <= pend_col_next;
      pend_white_reg  <= pend_white_next;
`ifdef TURN_TIMEOUT_EN
      timer_reg       <= timer_next;
`endif
    end
  end

  assign ai_enable   = (state_reg == AI_TURN);
  assign hum_enable  = (state_reg == HUM_TURN);
  assign cur_row     = (state_reg == AI_TURN) ? ai_row : hum_row;
  assign cur_col     = (state_reg == AI_TURN) ? ai_col : hum_col;
  assign board_black = board_black_reg;
  assign board_white = board_white_reg;
  assign last_row    = last_row_reg;
  assign last_col    = last_col_reg;
  assign who_win     = who_win_reg;
  assign move_count  = move_count_reg;
  assign illegal     = illegal_reg;

endmodule
